// File: rtl/masar_mac_accum.sv
// Frame accumulator downstream of the masar multiplier: sums LEN products into an ACC_W-bit total.
// Build option: define MASAR_ACC_SATURATE_EN to clamp on carry instead of wrapping.
module masar_mac_accum #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_t;

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   acc_out_reg;
    logic [LEN_W-1:0]   remaining_reg;
    logic               overflow_reg;
    logic               acc_valid_reg;
    logic               busy_reg;

    logic               beat;
    logic [ACC_W:0]     sum_wide;
    logic               carry;
    logic [ACC_W-1:0]   acc_next;

    assign beat     = prod_valid && (state_reg == ST_ACC);
    assign sum_wide = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry    = sum_wide[ACC_W];

`ifdef MASAR_ACC_SATURATE_EN
    // Products are unsigned, so once clamped any further carry re-clamps: the frame stays pinned.
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign acc_next = sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            acc_out_reg   <= '0;
            remaining_reg <= '0;
            overflow_reg  <= 1'b0;
            acc_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        acc_reg      <= '0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (len != '0) begin
                            remaining_reg <= len;
                            state_reg     <= ST_ACC;
                        end else begin
                            acc_out_reg   <= '0;
                            acc_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end
                ST_ACC: begin
                    if (beat) begin
                        acc_reg       <= acc_next;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (carry) begin
                            overflow_reg <= 1'b1;
                        end
                        if (remaining_reg == 1) begin
                            acc_out_reg   <= acc_next;
                            acc_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (acc_ready) begin
                        acc_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign prod_ready = (state_reg == ST_ACC);
    assign acc_out    = acc_out_reg;
    assign acc_valid  = acc_valid_reg;
    assign busy       = busy_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_masar_mac_accum.sv
// Randomized self-checking bench for masar_mac_accum; runs a 24-bit and a 17-bit instance in lockstep.
module tb_masar_mac_accum;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [15:0] prod;
    logic        prod_valid;
    logic        acc_ready;

    logic        prod_ready, acc_valid, busy, overflow;
    logic [23:0] acc_out;
    logic        prod_ready17, acc_valid17, busy17, overflow17;
    logic [16:0] acc_out17;

    int checks = 0;
    int errors = 0;
    int frame_prods[$];

    masar_mac_accum dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy), .overflow(overflow)
    );

    masar_mac_accum #(.ACC_W(17)) dut17 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready17), .acc_out(acc_out17),
        .acc_valid(acc_valid17), .acc_ready(acc_ready), .busy(busy17), .overflow(overflow17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: true unbounded sum, then apply the width rule for a given accumulator width.
    function automatic longint exp_result(input longint total, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef MASAR_ACC_SATURATE_EN
        return (total > mx) ? mx : total;
`else
        return total & mx;
`endif
    endfunction

    task automatic do_frame(input int max_gap, input int hold, input bit inject_start);
        longint total;
        int     n;
        logic [23:0] held;
        n = frame_prods.size();
        total = 0;
        foreach (frame_prods[i]) total += frame_prods[i];
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        len   = 8'($urandom);
        if (n == 0) begin
            @(negedge clk);
            check("zero_prod_ready", prod_ready, 1'b0);
        end else begin
            for (int i = 0; i < n; i++) begin
                int gap;
                gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
                prod_valid = 1'b0;
                prod       = 16'($urandom);
                for (int g = 0; g < gap; g++) tick();
                prod_valid = 1'b1;
                prod       = 16'(frame_prods[i]);
                if (inject_start && i == 0) begin
                    start = 1'b1;
                    len   = 8'd9;
                end
                @(negedge clk);
                check("mid_prod_ready", prod_ready, 1'b1);
                check("mid_acc_valid", acc_valid, 1'b0);
                tick();
                start = 1'b0;
            end
            prod_valid = 1'b0;
        end
        @(negedge clk);
        check("done_acc_valid", acc_valid, 1'b1);
        check("done_acc_valid17", acc_valid17, 1'b1);
        check("done_prod_ready", prod_ready, 1'b0);
        check("done_busy", busy, 1'b1);
        check("acc_out24", acc_out, exp_result(total, 24));
        check("overflow24", overflow, total > 64'hFF_FFFF);
        check("acc_out17", acc_out17, exp_result(total, 17));
        check("overflow17", overflow17, total > 64'h1_FFFF);
        held = acc_out;
        for (int h = 0; h < hold; h++) begin
            tick();
            @(negedge clk);
            check("hold_acc_valid", acc_valid, 1'b1);
            check("hold_acc_out", acc_out, exp_result(total, 24));
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        @(negedge clk);
        check("after_acc_valid", acc_valid, 1'b0);
        check("after_busy", busy, 1'b0);
        $display("frame len=%0d sum=%0d acc24=%0d acc17=%0d ovf17=%0d", n, total, acc_out, acc_out17, overflow17);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; acc_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_acc_valid", acc_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_acc_out", acc_out, 0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_prod_ready", prod_ready, 1'b0);
        rst = 1'b0;
        tick();

        // Basic frame
        frame_prods = '{3465, 66};
        do_frame(0, 0, 1'b0);
        // Stalls with acc_ready held off
        frame_prods = '{1449, 3410, 408};
        for (int i = 0; i < 3; i++) begin
            start = (i == 0); len = 8'd3; tick(); start = 1'b0;
            if (i == 0) begin
                prod_valid = 1'b0;
            end
        end
        acc_ready = 1'b1; tick(); acc_ready = 1'b0;
        frame_prods = '{1449, 3410, 408};
        do_frame(2, 5, 1'b0);
        // Zero length
        frame_prods = {};
        do_frame(0, 1, 1'b0);
        // Overflow on the 17-bit instance
        frame_prods = '{65535, 65535, 65535};
        do_frame(0, 0, 1'b0);
        // Start pulsed during ACC must be ignored
        frame_prods = '{3465, 66};
        do_frame(1, 0, 1'b1);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int n;
            n = int'($urandom_range(20));
            frame_prods = {};
            for (int i = 0; i < n; i++) begin
                frame_prods.push_back((f % 3 == 0) ? int'($urandom_range(65535, 60000)) : int'($urandom_range(65535)));
            end
            do_frame(2, int'($urandom_range(3)), f[0]);
        end

        // Asynchronous reset mid-frame: partial sum discarded, no result afterwards
        start = 1'b1; len = 8'd5; tick(); start = 1'b0;
        prod_valid = 1'b1; prod = 16'd1000;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_prod_ready", prod_ready, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_acc_valid", acc_valid, 1'b0);
        check("arst_acc_out", acc_out, 0);
        tick();
        rst = 1'b0;
        repeat (8) begin
            tick();
            @(negedge clk);
            check("post_rst_acc_valid", acc_valid, 1'b0);
            check("post_rst_prod_ready", prod_ready, 1'b0);
        end
        prod_valid = 1'b0;
        frame_prods = '{3465, 66};
        do_frame(0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
